// File: rtl/mdu_sequencer.sv
// -----------------------------------------------------------------------------
// mdu_sequencer
//   Iterative RV32M multiply/divide unit that sits beside the EX-stage ALU.
//   MUL/MULH/MULHSU/MULHU use a shift-add multiplier. DIV/DIVU/REM/REMU use a
//   restoring divider. Both run on operand magnitudes, and the sign is fixed
//   in DONE. The unit holds the pipeline with `stall` while it works, then
//   pulses `result_valid` with the registered `result`.
//
//   Optional feature: define MDU_EARLY_OUT_EN to skip CALC for ops whose
//   result is known up front (divide by zero, signed overflow, multiply by
//   zero). Results are identical either way; only latency changes.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   valid        EX stage holds an M-extension instruction
//   func3[2:0]   M-op select (MUL..REMU)
//   rs1[W-1:0]   operand A (multiplicand / dividend)
//   rs2[W-1:0]   operand B (multiplier / divisor)
//   flush        kill the in-flight op
//   stall        freeze PC, IF/ID and ID/EX
//   busy         state is not IDLE
//   result       registered result, held between completions
//   result_valid one-cycle pulse marking a new result
// -----------------------------------------------------------------------------
module mdu_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [2:0]       func3,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    typedef enum logic [2:0] {
        OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011,
        OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM    = 3'b110, OP_REMU  = 3'b111
    } op_e;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    op_e                  op_q, op_d;
    logic                 neg_q, neg_d;     // negate the selected magnitude in DONE
    logic                 dz_q, dz_d;       // divisor was zero
    logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand (mul) or divisor (div)
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // {hi, lo} product or {rem, quo}
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 rv_q, rv_d;

    // ---- operand conditioning at accept time --------------------------------
    op_e              op_in;
    logic             is_div_in, sa_in, sb_in, dz_in;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign op_in     = op_e'(func3);
    assign is_div_in = func3[2];
    assign sa_in     = rs1[WIDTH-1] & (op_in == OP_MULH || op_in == OP_MULHSU ||
                                       op_in == OP_DIV  || op_in == OP_REM);
    assign sb_in     = rs2[WIDTH-1] & (op_in == OP_MULH || op_in == OP_DIV ||
                                       op_in == OP_REM);
    assign mag_a     = sa_in ? -rs1 : rs1;
    assign mag_b     = sb_in ? -rs2 : rs2;
    assign dz_in     = (rs2 == '0);

`ifdef MDU_EARLY_OUT_EN
    logic ovf_in, trivial_in;
    assign ovf_in     = is_div_in & ~func3[0] &
                        (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) & (&rs2);
    assign trivial_in = is_div_in ? (dz_in | ovf_in) : (rs1 == '0 || rs2 == '0);
`endif

    // ---- one iteration of each algorithm ------------------------------------
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next;

    // Shift-add: add the multiplicand into the high half on a 1 LSB, then
    // shift the whole accumulator right, keeping the carry.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring: trial-subtract from the left-shifted remainder. That value
    // needs WIDTH+1 bits because the remainder can use all WIDTH bits.
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // ---- sign correction and output select ----------------------------------
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   div_sel, div_res, done_res;

    assign prod    = neg_q ? -acc_q : acc_q;
    assign div_sel = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];

    always_comb begin
        div_res = neg_q ? -div_sel : div_sel;
        // A zero divisor gives an all-ones quotient whatever the operand signs.
        if (dz_q && !op_q[1]) div_res = '1;
        if (op_q[2])              done_res = div_res;
        else if (op_q == OP_MUL)  done_res = prod[WIDTH-1:0];
        else                      done_res = prod[2*WIDTH-1:WIDTH];
    end

    // ---- next state / outputs -----------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and infers a latch.
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        rv_d     = 1'b0;
        stall    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid && !flush) begin
                    stall   = 1'b1;
                    count_d = '0;
                    op_d    = op_in;
                    dz_d    = dz_in;
                    // The remainder takes the dividend's sign. Everything else
                    // takes the XOR of both signs.
                    neg_d   = (is_div_in && func3[1]) ? sa_in : (sa_in ^ sb_in);
                    opnd_d  = is_div_in ? mag_b : mag_a;
                    acc_d   = {{WIDTH{1'b0}}, (is_div_in ? mag_a : mag_b)};
                    state_d = CALC;
`ifdef MDU_EARLY_OUT_EN
                    if (trivial_in) begin
                        // Preload the final magnitudes so DONE needs no special path.
                        // Overflow already has them: quo = |rs1|, rem = 0.
                        if (is_div_in && dz_in) acc_d = {mag_a, {WIDTH{1'b1}}};
                        else if (!is_div_in)    acc_d = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                stall   = 1'b1;
                count_d = count_q + 1'b1;
                acc_d   = op_q[2] ? div_next : mul_next;
                if (count_q == LAST_ITER) state_d = DONE;
            end
            DONE: begin
                result_d = done_res;
                rv_d     = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d  = IDLE;
            count_d  = '0;
            rv_d     = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values, so order here is irrelevant.
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rv_q     <= rv_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign result       = result_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mdu_sequencer
//   Directed bench for mdu_sequencer (WIDTH=32). Stimulus pushes the expected
//   result into a scoreboard queue. A monitor pops and compares it on every
//   result_valid pulse. Latency, stall, back-to-back, flush and reset
//   behaviour are checked from the stimulus thread.
// -----------------------------------------------------------------------------
module tb_mdu_sequencer;

    localparam int W = 32;

`ifdef MDU_EARLY_OUT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   func3 = 3'b000;
    logic [W-1:0] rs1 = '0;
    logic [W-1:0] rs2 = '0;
    logic         stall, busy, result_valid;
    logic [W-1:0] result;

    mdu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .func3(func3),
        .rs1(rs1), .rs2(rs2), .flush(flush), .stall(stall), .busy(busy),
        .result(result), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    int           pass_cnt = 0;
    int           total_cnt = 0;
    int           cyc = 0;
    logic [W-1:0] exp_q[$];
    int           pulse_cyc[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            pulse_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("unexpected result_valid", 32'd1, 32'd0);
            else check("result", result, exp_q.pop_front());
        end
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV] = '{
        '{3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB},  // MUL 7*-3
        '{3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE},  // MULHU
        '{3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000},  // MULH -1*-1
        '{3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF},  // MULHSU -1*(2^32-1)
        '{3'b000, 32'd0,          32'd5,        32'd0},         // MUL by zero
        '{3'b011, 32'h12345678,   32'd0,        32'd0},         // MULHU by zero
        '{3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD},  // DIV -7/2
        '{3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF},  // REM -7/2
        '{3'b101, 32'd100,        32'd7,        32'd14},        // DIVU
        '{3'b111, 32'd100,        32'd7,        32'd2},         // REMU
        '{3'b100, 32'h00001234,   32'd0,        32'hFFFFFFFF},  // DIV /0
        '{3'b101, 32'h00001234,   32'd0,        32'hFFFFFFFF},  // DIVU /0
        '{3'b110, 32'h00001234,   32'd0,        32'h00001234},  // REM /0
        '{3'b111, 32'h00001234,   32'd0,        32'h00001234},  // REMU /0
        '{3'b100, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF},  // DIV -5/0
        '{3'b110, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB},  // REM -5/0
        '{3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000},  // DIV overflow
        '{3'b110, 32'h80000000,   32'hFFFFFFFF, 32'h00000000},  // REM overflow
        '{3'b101, 32'h80000000,   32'hFFFFFFFF, 32'h00000000},  // DIVU, not overflow
        '{3'b111, 32'h80000000,   32'hFFFFFFFF, 32'h80000000},  // REMU, not overflow
        '{3'b100, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2}   // DIV 100/-7
    };

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic trivial;
        if (f3[2]) trivial = (b == 0) || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
        else       trivial = (a == 0) || (b == 0);
        return trivial ? EARLY_LAT : W + 2;
    endfunction

    // Returns at posedge+1 with the DUT in IDLE.
    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!busy) return;
        end
        check("idle timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_pulse(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (result_valid) return;
        end
        check(name, 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input int lat);
        int n, st;
        wait_idle();
        valid = 1'b1; func3 = f3; rs1 = a; rs2 = b;
        exp_q.push_back(r);
        @(negedge clk);
        st = stall;                          // accept cycle
        @(posedge clk); #1 valid = 1'b0;
        for (n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (result_valid) break;
            st += stall;
        end
        check("latency", n, lat);
        check("stall cycles", st, lat - 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;

        // Reset state.
        #12;
        check("reset stall", stall, 0);
        check("reset busy", busy, 0);
        check("reset result", result, 0);
        check("reset result_valid", result_valid, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed vectors.
        foreach (vecs[i])
            do_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].r,
                  exp_lat(vecs[i].f3, vecs[i].a, vecs[i].b));

        // Back-to-back MULs: valid stays high, and the second op is taken in the
        // IDLE cycle that carries the first result.
        wait_idle();
        base = pulse_cyc.size();
        valid = 1'b1; func3 = 3'b000; rs1 = 32'd5; rs2 = 32'd6;
        exp_q.push_back(32'd30);
        @(posedge clk); #1 rs1 = 32'd8; rs2 = 32'd9;
        exp_q.push_back(32'd72);
        wait_pulse("b2b first pulse timeout");
        check("b2b idle between", busy, 0);
        check("b2b stall on accept", stall, 1);
        @(posedge clk); #1 valid = 1'b0;
        check("b2b second accepted", busy, 1);
        wait_pulse("b2b second pulse timeout");
        #1;
        if (pulse_cyc.size() >= base + 2)
            check("b2b pulse spacing", pulse_cyc[base+1] - pulse_cyc[base], W + 2);
        else
            check("b2b pulse count", pulse_cyc.size() - base, 2);

        // flush and valid together in IDLE: the op is not taken.
        wait_idle();
        valid = 1'b1; flush = 1'b1; func3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4;
        #1 check("flush+valid stall", stall, 0);
        @(posedge clk); #1;
        check("flush+valid busy", busy, 0);
        valid = 1'b0; flush = 1'b0;

        // Flush at CALC count=10: IDLE next cycle, no pulse, result held.
        wait_idle();
        valid = 1'b1; func3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4;
        @(posedge clk); #1 valid = 1'b0;     // accept edge
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("flush busy", busy, 0);
        check("flush stall", stall, 0);
        repeat (40) @(posedge clk);
        #1 check("flush result held", result, 32'd72);

        // Reset mid-CALC: takes effect immediately and clears result.
        wait_idle();
        valid = 1'b1; func3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge clk); #1 valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset busy", busy, 0);
        check("mid reset stall", stall, 0);
        check("mid reset result", result, 0);
        check("mid reset result_valid", result_valid, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        do_op(3'b000, 32'd5, 32'd6, 32'd30, W + 2);

        repeat (3) @(posedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative controller and datapath for the RV32M multiply/divide group.
- Sits beside the EX-stage ALU and takes the instruction when the decoder flags an M-extension op (funct7 = 0000001).
- Sequences a shift-add multiplier or a restoring divider over WIDTH cycles.
- Holds the pipeline with `stall` until the result is ready, then presents the result for one cycle so it can be written into EX/MEM.

Parameters:
- WIDTH, 32, operand and result width in bits; must be ≥ 4 and a power of two.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- valid  input  1  EX stage holds an M-extension instruction.
- func3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  WIDTH  operand A (dividend / multiplicand).
- rs2  input  WIDTH  operand B (divisor / multiplier).
- flush  input  1  kill the in-flight op (branch mispredict or trap).
- stall  output  1  freeze PC, IF/ID and ID/EX.
- busy  output  1  state ≠ IDLE.
- result  output  WIDTH  registered result.
- result_valid  output  1  one-cycle pulse; `result` is valid in that cycle.

Behaviour:
- Reset, asynchronous, on rst_n low:
  - state = IDLE, count = 0.
  - result = 0, result_valid = 0.
  - All internal accumulator and operand registers cleared.
  - Reset mid-operation abandons the op silently.
- States: IDLE, CALC, DONE.
- IDLE:
  - On valid=1 and flush=0, latch func3, rs1, rs2; count = 0; go to CALC.
  - Signed ops (MULH/DIV/REM: both operands; MULHSU: rs1 only) latch operand magnitudes and record the result sign:
    - product sign = sA ^ sB;
    - quotient sign = sA ^ sB;
    - remainder sign = sA.
- CALC:
  - One iteration per cycle; count increments; leave CALC after the iteration with count = WIDTH-1, i.e. exactly WIDTH cycles.
  - Multiply: 2·WIDTH-bit accumulator; add the multiplicand when the current multiplier LSB is 1, then shift right one bit.
  - Divide (restoring): shift {rem, quo} left one bit; trial-subtract the divisor; keep the difference and set the quotient bit when there is no borrow.
  - Then go to DONE.
- DONE:
  - Apply the sign correction (two's-complement negate) and select the output:
    - MUL: low half of the product;
    - MULH/MULHSU/MULHU: high half;
    - DIV/DIVU: quotient;
    - REM/REMU: remainder.
  - Register into `result`, pulse result_valid = 1, go to IDLE.
  - `valid` is ignored in DONE; the completing instruction advances at the end of this cycle.
- stall = (state==IDLE & valid & ~flush) | (state==CALC). It is low in DONE.
- Latency: valid sampled at edge T → result_valid high in the cycle after edge T+WIDTH+1, i.e. WIDTH+2 cycles of occupancy including DONE.
- Back-to-back: a new valid is accepted in IDLE the cycle after DONE. There are no bubbles beyond that.
- Special cases (RISC-V mandated), with the result produced through the normal WIDTH-cycle path:
  - Divide by zero: quotient = all ones (DIV and DIVU); remainder = rs1.
  - Signed overflow (rs1 = 2^(WIDTH-1), rs2 = −1, DIV/REM): quotient = rs1, remainder = 0.
- Flush:
  - In any state, the next edge forces IDLE with count = 0 and no result_valid.
  - `result` keeps its previous value.
  - flush and valid together in IDLE: not accepted, and stall stays 0.
- `result` holds its value between completions.
- `busy` is combinational from state.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined:
  - In IDLE, ops with a trivially known result skip CALC and go straight to DONE, giving result_valid on the second cycle (two cycles of occupancy).
  - Trivial cases: divide by zero, signed overflow, and multiply with either operand zero.
  - stall behaves the same (high in the IDLE accept cycle, low in DONE).
- Undefined: every op takes the full WIDTH-cycle path; results are identical.

Test Plan (WIDTH=32):
- MUL rs1=7, rs2=−3 → stall high 33 cycles; result_valid pulse 34 cycles after accept; result=0xFFFFFFEB.
- MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → result=0xFFFFFFFE. MULH with the same operands → result=0x00000000.
- DIV rs1=−7, rs2=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV and DIVU with rs2=0, rs1=0x1234 → 0xFFFFFFFF. REM and REMU with the same operands → 0x1234. DIV 0x80000000/−1 → 0x80000000. REM 0x80000000/−1 → 0.
- Two back-to-back MULs (5×6, 8×9) → two result_valid pulses, 30 then 72, one IDLE cycle between them. Flush asserted at CALC count=10 → IDLE next cycle, no pulse, result still 72.
- rst_n low mid-CALC → immediately state=IDLE, result=0, stall=0. With MDU_EARLY_OUT_EN, DIVU by 0 → result_valid on the 2nd cycle.
